// File: rtl/alu_cmd_master.sv
// alu_cmd_master: command-side initiator for a 32-bit ALU.
// Accepts upstream commands over valid/ready and drives the ALU a/b/op/en inputs.
// Waits for ack (after SETTLE cycles) and captures res, with a TIMEOUT bound on each access.
// Screens divide-by-zero before issue and returns a tagged result with an error code downstream.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   i_cmd_valid / o_cmd_ready     command handshake
//   i_cmd_op/a/b/tag              command payload
//   o_rsp_valid / i_rsp_ready     response handshake
//   o_rsp_res/err/tag             response payload (err: 00 ok, 01 div0, 10 timeout)
//   o_alu_a/b/op/en               ALU request side
//   i_alu_res, i_alu_ack          ALU result side (ack sampled as a level)
//   o_busy                        high whenever not IDLE
module alu_cmd_master #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SETTLE  = 1,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_op,
    input  logic [WIDTH-1:0] i_cmd_a,
    input  logic [WIDTH-1:0] i_cmd_b,
    input  logic [3:0]       i_cmd_tag,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_res,
    output logic [1:0]       o_rsp_err,
    output logic [3:0]       o_rsp_tag,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [2:0]       o_alu_op,
    output logic             o_alu_en,
    input  logic [WIDTH-1:0] i_alu_res,
    input  logic             i_alu_ack,
    output logic             o_busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    // One-hot state so every control output is a direct flop bit.
    localparam logic [2:0] S_IDLE  = 3'b001;
    localparam logic [2:0] S_ISSUE = 3'b010;
    localparam logic [2:0] S_RESP  = 3'b100;

    localparam logic [2:0] OP_DIV  = 3'b110;
    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_DIV = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_op;
    logic [3:0]       r_tag;
    logic [WIDTH-1:0] r_rsp_res;
    logic [1:0]       r_rsp_err;

    logic w_accept;
    logic w_div0;
    logic w_capture;
    logic w_timeout;

    assign w_accept  = r_state[0] & i_cmd_valid;
    assign w_div0    = (i_cmd_op == OP_DIV) && (i_cmd_b == '0);
    // Capture wins over timeout when both are possible in the same cycle.
    assign w_capture = r_state[1] && (r_cnt >= CNT_W'(SETTLE)) && i_alu_ack;
    assign w_timeout = r_state[1] && !w_capture && (r_cnt == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_div0 ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_capture || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control outputs taken straight from the one-hot state flops.
    always_comb begin
        o_cmd_ready = 1'b0;
        o_alu_en    = 1'b0;
        o_rsp_valid = 1'b0;
        o_busy      = 1'b0;
        o_cmd_ready = r_state[0];
        o_alu_en    = r_state[1];
        o_rsp_valid = r_state[2];
        o_busy      = ~r_state[0];
    end

    // Datapath: operand/tag capture on accept, response capture on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_tag     <= '0;
            r_rsp_res <= '0;
            r_rsp_err <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a  <= i_cmd_a;
                r_alu_b  <= i_cmd_b;
                r_alu_op <= i_cmd_op;
                r_tag    <= i_cmd_tag;
                r_cnt    <= '0;
                if (w_div0) begin
                    r_rsp_res <= '0;
                    r_rsp_err <= ERR_DIV;
                end
            end else if (w_capture) begin
                r_rsp_res <= i_alu_res;
                r_rsp_err <= ERR_OK;
            end else if (w_timeout) begin
                r_rsp_res <= '0;
                r_rsp_err <= ERR_TMO;
            end else if (r_state[1]) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_alu_a   = r_alu_a;
    assign o_alu_b   = r_alu_b;
    assign o_alu_op  = r_alu_op;
    assign o_rsp_res = r_rsp_res;
    assign o_rsp_err = r_rsp_err;
    assign o_rsp_tag = r_tag;

endmodule

// File: tb/tb_alu_cmd_master.sv
// Directed testbench for alu_cmd_master (WIDTH=32, SETTLE=1, TIMEOUT=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_cmd_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [3:0]  cmd_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res;
    logic [1:0]  rsp_err;
    logic [3:0]  rsp_tag;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic        alu_en;
    logic [31:0] alu_res;
    logic        alu_ack;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    alu_cmd_master #(.WIDTH(32), .SETTLE(1), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_a     (cmd_a),
        .i_cmd_b     (cmd_b),
        .i_cmd_tag   (cmd_tag),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_res   (rsp_res),
        .o_rsp_err   (rsp_err),
        .o_rsp_tag   (rsp_tag),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_op    (alu_op),
        .o_alu_en    (alu_en),
        .i_alu_res   (alu_res),
        .i_alu_ack   (alu_ack),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: purely combinational result; ack level controlled by the bench.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            3'b000: alu_res = alu_a + alu_b;
            3'b001: alu_res = alu_a - alu_b;
            3'b010: alu_res = alu_a + 32'd1;
            3'b011: alu_res = alu_a - 32'd1;
            3'b100: alu_res = alu_a;
            3'b101: alu_res = ~alu_a;
            3'b110: alu_res = (alu_b == '0) ? '0 : alu_a / alu_b;
            default: alu_res = alu_a & alu_b;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Issue one command with rsp_ready high and check latency, enable count and response.
    task automatic run_cmd(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] tag,
                           input logic [31:0] exp_res, input logic [1:0] exp_err,
                           input int exp_en, input int exp_lat);
        int n_en;
        int lat;
        bit seen;
        check_eq({name, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        tick();
        cmd_valid = 1'b0;
        n_en = 0;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (alu_en) n_en++;
            tick();
            lat++;
        end
        check_eq({name, "_rsp_seen"}, 32'(seen), 32'd1);
        check_eq({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({name, "_en_cycles"}, 32'(n_en), 32'(exp_en));
        check_eq({name, "_res"}, rsp_res, exp_res);
        check_eq({name, "_err"}, 32'(rsp_err), 32'(exp_err));
        check_eq({name, "_tag"}, 32'(rsp_tag), 32'(tag));
        tick();
        check_eq({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int bad;
        bit seen;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_tag   = '0;
        rsp_ready = 1'b1;
        alu_ack   = 1'b1;
        tick();
        tick();

        // Reset values.
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_alu_en", 32'(alu_en), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_res", rsp_res, 32'd0);
        check_eq("rst_alu_a", alu_a, 32'd0);
        rst_n = 1'b1;
        tick();

        // Add with ack already high: en 2 cycles, rsp_valid 3 cycles after accept.
        run_cmd("add",  3'b000, 32'd5,   32'd7, 4'd3, 32'd12,        2'b00, 2, 3);
        // Divide-by-zero screened: no enable, response next cycle.
        run_cmd("div0", 3'b110, 32'd9,   32'd0, 4'd4, 32'd0,         2'b01, 0, 1);
        run_cmd("div",  3'b110, 32'd100, 32'd7, 4'd5, 32'd14,        2'b00, 2, 3);
        run_cmd("inc",  3'b010, 32'hFFFF_FFFF, 32'd0, 4'd6, 32'd0,   2'b00, 2, 3);
        run_cmd("dec",  3'b011, 32'd0,   32'd0, 4'd7, 32'hFFFF_FFFF, 2'b00, 2, 3);
        run_cmd("and",  3'b111, 32'hF0F0_1234, 32'h0FF0_FF00, 4'd8, 32'h00F0_1200, 2'b00, 2, 3);

        // Ack held low: exactly 16 enable cycles then timeout.
        alu_ack = 1'b0;
        run_cmd("tmo",  3'b001, 32'd10,  32'd3, 4'd9, 32'd0,         2'b10, 16, 17);
        alu_ack = 1'b1;

        // Backpressure with a second command waiting.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = 3'b000; cmd_a = 32'd1; cmd_b = 32'd2; cmd_tag = 4'd10;
        tick();
        cmd_op = 3'b001; cmd_a = 32'd9; cmd_b = 32'd4; cmd_tag = 4'd11;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_eq("bp_rsp_seen", 32'(seen), 32'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_res !== 32'd3 ||
                rsp_err !== 2'b00 || rsp_tag !== 4'd10) bad++;
            tick();
        end
        check_eq("bp_hold", 32'(bad), 32'd0);
        check_eq("bp_res", rsp_res, 32'd3);
        rsp_ready = 1'b1;
        tick();
        check_eq("bp_idle_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check_eq("bp_second_en", 32'(alu_en), 32'd1);
        check_eq("bp_second_a", alu_a, 32'd9);
        tick();
        tick();
        check_eq("bp_second_valid", 32'(rsp_valid), 32'd1);
        check_eq("bp_second_res", rsp_res, 32'd5);
        check_eq("bp_second_tag", 32'(rsp_tag), 32'd11);
        tick();

        // Reset in the middle of ISSUE.
        alu_ack   = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = 3'b000; cmd_a = 32'd20; cmd_b = 32'd22; cmd_tag = 4'd12;
        tick();
        cmd_valid = 1'b0;
        tick();
        check_eq("mid_alu_en", 32'(alu_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_alu_en", 32'(alu_en), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("mid_rst_alu_a", alu_a, 32'd0);
        tick();
        rst_n   = 1'b1;
        alu_ack = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 1'b0 || alu_en !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        check_eq("mid_no_rsp", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
